// File: rtl/q_collect_stage.sv
// q_collect_stage
// Collects single-bit tokens (po, so, f) from the Q-flop pipeline stage into
// WIDTH-bit po/so words plus f statistics. Holds two words: one on the output
// and one being collected. Upstream stalls only when both are occupied.
//
// Ports:
//   clk        clock, all state changes on the rising edge
//   rst        asynchronous reset, active-low
//   start      synchronous frame restart, clears the partial word
//   in_valid   upstream token present
//   in_ready   token accepted when in_valid && in_ready
//   po, so, f  token bits
//   out_valid  output word present
//   out_ready  consumer takes the word when out_valid && out_ready
//   po_word    assembled po bits
//   so_word    assembled so bits
//   f_count    number of beats in the word with f=1
//   f_last     f value of the word's final beat
module q_collect_stage #(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         po,
  input  logic                         so,
  input  logic                         f,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             po_word,
  output logic [WIDTH-1:0]             so_word,
  output logic [$clog2(WIDTH+1)-1:0]   f_count,
  output logic                         f_last
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BEAT = CW'(WIDTH - 1);
  localparam logic [CW-1:0] FULL_CNT  = CW'(WIDTH);

  typedef enum logic [1:0] {
    EMPTY,   // no word on the output
    FULL,    // word on the output, collecting the next one
    STALL    // word on the output and a complete word parked in the shifters
  } state_t;

  state_t            state_q;
  logic [CW-1:0]     bit_cnt_q;
  logic [WIDTH-1:0]  po_sh_q;
  logic [WIDTH-1:0]  so_sh_q;
  logic [CW-1:0]     acc_q;
  logic              pend_flast_q;
  logic [WIDTH-1:0]  po_word_q;
  logic [WIDTH-1:0]  so_word_q;
  logic [CW-1:0]     f_count_q;
  logic              f_last_q;
  logic              out_valid_q;

  // Shift-register contents after taking the current beat.
  logic [WIDTH-1:0]  po_sh_d;
  logic [WIDTH-1:0]  so_sh_d;
  logic [CW-1:0]     acc_d;
  logic              accept;
  logic              complete;

  generate
    if (LSB_FIRST) begin : g_lsb_first
      // First beat ends up in bit 0 after WIDTH right shifts.
      assign po_sh_d = {po, po_sh_q[WIDTH-1:1]};
      assign so_sh_d = {so, so_sh_q[WIDTH-1:1]};
    end else begin : g_msb_first
      assign po_sh_d = {po_sh_q[WIDTH-2:0], po};
      assign so_sh_d = {so_sh_q[WIDTH-2:0], so};
    end
  endgenerate

  assign acc_d    = acc_q + {{(CW-1){1'b0}}, f};
  assign in_ready = ~start && (state_q != STALL);
  assign accept   = in_valid && in_ready;
  assign complete = (bit_cnt_q == LAST_BEAT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= EMPTY;
      bit_cnt_q    <= '0;
      po_sh_q      <= '0;
      so_sh_q      <= '0;
      acc_q        <= '0;
      pend_flast_q <= 1'b0;
      po_word_q    <= '0;
      so_word_q    <= '0;
      f_count_q    <= '0;
      f_last_q     <= 1'b0;
      out_valid_q  <= 1'b0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (start) begin
            bit_cnt_q <= '0;
            po_sh_q   <= '0;
            so_sh_q   <= '0;
            acc_q     <= '0;
          end else if (accept) begin
            if (complete) begin
              po_word_q   <= po_sh_d;
              so_word_q   <= so_sh_d;
              f_count_q   <= acc_d;
              f_last_q    <= f;
              out_valid_q <= 1'b1;
              bit_cnt_q   <= '0;
              po_sh_q     <= '0;
              so_sh_q     <= '0;
              acc_q       <= '0;
              state_q     <= FULL;
            end else begin
              po_sh_q   <= po_sh_d;
              so_sh_q   <= so_sh_d;
              acc_q     <= acc_d;
              bit_cnt_q <= bit_cnt_q + CW'(1);
            end
          end
        end

        FULL: begin
          // Consumer takes the word with no replacement ready: drain.
          if (out_ready && !(accept && complete)) begin
            out_valid_q <= 1'b0;
            state_q     <= EMPTY;
          end
          // accept already implies !start here.
          if (start) begin
            bit_cnt_q <= '0;
            po_sh_q   <= '0;
            so_sh_q   <= '0;
            acc_q     <= '0;
          end else if (accept) begin
            if (complete && out_ready) begin
              // Back-to-back: new word replaces the taken one, no bubble.
              po_word_q <= po_sh_d;
              so_word_q <= so_sh_d;
              f_count_q <= acc_d;
              f_last_q  <= f;
              bit_cnt_q <= '0;
              po_sh_q   <= '0;
              so_sh_q   <= '0;
              acc_q     <= '0;
            end else if (complete) begin
              // Output still occupied: park the finished word in the shifters.
              po_sh_q      <= po_sh_d;
              so_sh_q      <= so_sh_d;
              acc_q        <= acc_d;
              pend_flast_q <= f;
              bit_cnt_q    <= FULL_CNT;
              state_q      <= STALL;
            end else begin
              po_sh_q   <= po_sh_d;
              so_sh_q   <= so_sh_d;
              acc_q     <= acc_d;
              bit_cnt_q <= bit_cnt_q + CW'(1);
            end
          end
        end

        STALL: begin
          if (start) begin
            // Parked word is discarded; the output word is left alone.
            bit_cnt_q <= '0;
            po_sh_q   <= '0;
            so_sh_q   <= '0;
            acc_q     <= '0;
            if (out_ready) begin
              out_valid_q <= 1'b0;
              state_q     <= EMPTY;
            end else begin
              state_q <= FULL;
            end
          end else if (out_ready) begin
            po_word_q <= po_sh_q;
            so_word_q <= so_sh_q;
            f_count_q <= acc_q;
            f_last_q  <= pend_flast_q;
            bit_cnt_q <= '0;
            po_sh_q   <= '0;
            so_sh_q   <= '0;
            acc_q     <= '0;
            state_q   <= FULL;
          end
        end

        default: begin
          state_q <= EMPTY;
        end
      endcase
    end
  end

  assign po_word   = po_word_q;
  assign so_word   = so_word_q;
  assign f_count   = f_count_q;
  assign f_last    = f_last_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_q_collect_stage.sv
// Testbench for q_collect_stage: two instances (LSB-first and MSB-first,
// WIDTH=4) driven by the same token stream. Expected words are queued when
// stimulus is issued; a monitor pops and compares on every output handshake.
module tb_q_collect_stage;

  logic       clk;
  logic       rst;
  logic       start;
  logic       in_valid;
  logic       po;
  logic       so;
  logic       f;
  logic       out_ready;

  logic       l_in_ready, m_in_ready;
  logic       l_out_valid, m_out_valid;
  logic [3:0] l_po_word, l_so_word, m_po_word, m_so_word;
  logic [2:0] l_f_count, m_f_count;
  logic       l_f_last, m_f_last;

  int total = 0;
  int bad   = 0;

  // {po_word, so_word, f_count, f_last}
  logic [11:0] q_l[$];
  logic [11:0] q_m[$];

  q_collect_stage #(.WIDTH(4), .LSB_FIRST(1'b1)) u_lsb (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(l_in_ready),
    .po(po), .so(so), .f(f), .out_valid(l_out_valid), .out_ready(out_ready),
    .po_word(l_po_word), .so_word(l_so_word), .f_count(l_f_count), .f_last(l_f_last)
  );

  q_collect_stage #(.WIDTH(4), .LSB_FIRST(1'b0)) u_msb (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(m_in_ready),
    .po(po), .so(so), .f(f), .out_valid(m_out_valid), .out_ready(out_ready),
    .po_word(m_po_word), .so_word(m_so_word), .f_count(m_f_count), .f_last(m_f_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, act, exp);
    end else begin
      $display("ok   %s = %h", name, act);
    end
  endtask

  task automatic expect_word(input logic [3:0] lpo, input logic [3:0] lso,
                             input logic [3:0] mpo, input logic [3:0] mso,
                             input logic [2:0] fc, input logic fl);
    q_l.push_back({lpo, lso, fc, fl});
    q_m.push_back({mpo, mso, fc, fl});
  endtask

  task automatic beat(input logic p, input logic s, input logic fl);
    in_valid = 1'b1;
    po = p;
    so = s;
    f  = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare on every handshake, sampled mid-cycle.
  always @(negedge clk) begin
    logic [11:0] e;
    if (rst) begin
      if (l_out_valid && out_ready) begin
        total++;
        if (q_l.size() == 0) begin
          bad++;
          $display("FAIL lsb_unexpected_word got=%h", {l_po_word, l_so_word, l_f_count, l_f_last});
        end else begin
          e = q_l.pop_front();
          if ({l_po_word, l_so_word, l_f_count, l_f_last} !== e) begin
            bad++;
            $display("FAIL lsb_word got=%h exp=%h", {l_po_word, l_so_word, l_f_count, l_f_last}, e);
          end else begin
            $display("ok   lsb_word = %h", e);
          end
        end
      end
      if (m_out_valid && out_ready) begin
        total++;
        if (q_m.size() == 0) begin
          bad++;
          $display("FAIL msb_unexpected_word got=%h", {m_po_word, m_so_word, m_f_count, m_f_last});
        end else begin
          e = q_m.pop_front();
          if ({m_po_word, m_so_word, m_f_count, m_f_last} !== e) begin
            bad++;
            $display("FAIL msb_word got=%h exp=%h", {m_po_word, m_so_word, m_f_count, m_f_last}, e);
          end else begin
            $display("ok   msb_word = %h", e);
          end
        end
      end
    end
  end

  initial begin
    rst = 1'b0; start = 1'b0; in_valid = 1'b0;
    po = 1'b0; so = 1'b0; f = 1'b0; out_ready = 1'b0;
    #1;
    check("rst_out_valid", {15'd0, l_out_valid}, 16'd0);
    check("rst_po_word",   {12'd0, l_po_word}, 16'd0);
    check("rst_so_word",   {12'd0, m_so_word}, 16'd0);
    check("rst_f_count",   {13'd0, l_f_count}, 16'd0);
    check("rst_f_last",    {15'd0, l_f_last}, 16'd0);
    check("rst_in_ready",  {15'd0, l_in_ready}, 16'd1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;

    // Basic word, out_ready high.
    out_ready = 1'b1;
    expect_word(4'b1101, 4'b0100, 4'b1011, 4'b0010, 3'd2, 1'b1);
    beat(1, 0, 1); beat(0, 0, 0); beat(1, 1, 0); beat(1, 0, 1);
    check("t1_latency_l", {15'd0, l_out_valid}, 16'd1);
    check("t1_latency_m", {15'd0, m_out_valid}, 16'd1);
    idle();
    check("t1_drained", {15'd0, l_out_valid}, 16'd0);

    // Stall: two words with out_ready low.
    out_ready = 1'b0;
    expect_word(4'b0011, 4'b1010, 4'b1100, 4'b0101, 3'd4, 1'b1);
    expect_word(4'b1010, 4'b0111, 4'b0101, 4'b1110, 3'd4, 1'b1);
    beat(1, 0, 1); beat(1, 1, 1); beat(0, 0, 1); beat(0, 1, 1);
    beat(0, 1, 1); beat(1, 1, 1); beat(0, 1, 1); beat(1, 0, 1);
    check("t3_stall_in_ready", {15'd0, l_in_ready}, 16'd0);
    check("t3_stall_valid", {15'd0, l_out_valid}, 16'd1);
    beat(1, 1, 1); beat(1, 1, 1);
    check("t3_hold_po_l", {12'd0, l_po_word}, 16'h3);
    check("t3_hold_so_m", {12'd0, m_so_word}, 16'h5);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("t3_resume_in_ready", {15'd0, l_in_ready}, 16'd1);
    check("t3_second_valid", {15'd0, l_out_valid}, 16'd1);
    idle();

    // Completing beat on the same edge as out_ready: no bubble.
    out_ready = 1'b0;
    expect_word(4'b0101, 4'b0011, 4'b1010, 4'b1100, 3'd2, 1'b0);
    expect_word(4'b0110, 4'b1101, 4'b0110, 4'b1011, 3'd3, 1'b1);
    beat(1, 1, 1); beat(0, 1, 1); beat(1, 0, 0); beat(0, 0, 0);
    beat(0, 1, 0); beat(1, 0, 1); beat(1, 1, 1);
    out_ready = 1'b1;
    beat(0, 1, 1);
    check("t4b_nobubble_valid", {15'd0, l_out_valid}, 16'd1);
    check("t4b_nobubble_in_ready", {15'd0, m_in_ready}, 16'd1);
    idle();

    // 12 back-to-back beats with out_ready high.
    expect_word(4'b0001, 4'b1000, 4'b1000, 4'b0001, 3'd0, 1'b0);
    expect_word(4'b0111, 4'b0001, 4'b1110, 4'b1000, 3'd2, 1'b0);
    expect_word(4'b1100, 4'b0110, 4'b0011, 4'b0110, 3'd1, 1'b1);
    begin
      logic [11:0] pv, sv, fv;
      pv = 12'b1000_1110_0011;
      sv = 12'b0001_1000_0110;
      fv = 12'b0000_1010_0001;
      for (int k = 0; k < 12; k++) begin
        beat(pv[11-k], sv[11-k], fv[11-k]);
        check($sformatf("t4_valid_beat%0d", k + 1), {15'd0, l_out_valid},
              {15'd0, ((k % 4) == 3)});
      end
    end
    idle();

    // start pulse drops the partial word and the beat on its edge.
    expect_word(4'b1111, 4'b1001, 4'b1111, 4'b1001, 3'd0, 1'b0);
    beat(0, 1, 1); beat(0, 1, 1);
    start = 1'b1;
    in_valid = 1'b1; po = 1'b0; so = 1'b1; f = 1'b1;
    #1;
    check("t5_start_in_ready", {15'd0, l_in_ready}, 16'd0);
    @(posedge clk);
    #1;
    start = 1'b0;
    beat(1, 1, 0); beat(1, 0, 0); beat(1, 0, 0); beat(1, 1, 0);
    idle();

    // Asynchronous reset with a word on the output and a partial word.
    out_ready = 1'b0;
    repeat (6) beat(1, 1, 1);
    in_valid = 1'b0;
    check("t6_pre_valid", {15'd0, l_out_valid}, 16'd1);
    #2 rst = 1'b0;
    #1;
    check("t6_rst_valid_l", {15'd0, l_out_valid}, 16'd0);
    check("t6_rst_valid_m", {15'd0, m_out_valid}, 16'd0);
    check("t6_rst_po", {12'd0, l_po_word}, 16'd0);
    check("t6_rst_so", {12'd0, m_so_word}, 16'd0);
    check("t6_rst_fc", {13'd0, l_f_count}, 16'd0);
    check("t6_rst_fl", {15'd0, m_f_last}, 16'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Asynchronous reset while stalled.
    repeat (8) beat(1, 1, 1);
    in_valid = 1'b0;
    check("t6_stall_in_ready", {15'd0, l_in_ready}, 16'd0);
    #2 rst = 1'b0;
    #1;
    check("t6_stall_rst_valid", {15'd0, l_out_valid}, 16'd0);
    check("t6_stall_rst_in_ready", {15'd0, l_in_ready}, 16'd1);
    check("t6_stall_rst_po", {12'd0, m_po_word}, 16'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    out_ready = 1'b1;
    expect_word(4'b1110, 4'b0100, 4'b0111, 4'b0010, 3'd2, 1'b1);
    beat(0, 0, 1); beat(1, 0, 0); beat(1, 1, 0); beat(1, 0, 1);
    idle();
    idle();

    check("end_queue_l", 16'(q_l.size()), 16'd0);
    check("end_queue_m", 16'(q_m.size()), 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
